// File: rtl/procik_mem_pkg.sv
// rtl/procik_mem_pkg.sv - shared SRAM geometry, controller state type and counter sizing helper
package procik_mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 256;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    OUTEN,
    SAMPLE,
    RECOVER
  } sram_ctrl_state_t;

  // Bits needed to hold max_val; never less than one so a zero range still builds.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if (max_val >= (1 << i)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request/response handshake between the core and the SRAM controller
interface sram_ctrl_if;
  import procik_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/SRAM256x16.sv
// rtl/SRAM256x16.sv - behavioural model of the single-port 256x16 SRAM macro
module SRAM256x16
  import procik_mem_pkg::*;
(
  input  logic              CE1,
  input  logic              CSB1,
  input  logic              WEB1,
  input  logic              OEB1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [DATA_W-1:0] I1,
  output logic [DATA_W-1:0] O1
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];
  logic [DATA_W-1:0] r_dout;

  // The access happens on the CE rising edge; OEB only gates the output driver.
  always_ff @(posedge CE1) begin
    if (!CSB1) begin
      if (!WEB1) r_mem[A1] <= I1;
      else       r_dout    <= r_mem[A1];
    end
  end

  assign O1 = OEB1 ? {DATA_W{1'bz}} : r_dout;

endmodule

// File: rtl/sram_phase_cnt.sv
// rtl/sram_phase_cnt.sv - loadable wait-state down-counter with zero flag
module sram_phase_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so the zero flag stays asserted while the FSM is parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - initiator-side controller sequencing CSB/WEB/CE/OEB for the SRAM256x16 macro
module sram_ctrl
  import procik_mem_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              sram_ce,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb
);

  localparam int WAIT_MAX = ((SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC) - 1;
  localparam int CNT_W    = cnt_width(WAIT_MAX);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);

  sram_ctrl_state_t  r_state;
  sram_ctrl_state_t  w_state_nxt;

  logic              w_accept;
  logic              w_we_eff;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_cnt_zero;

  logic              r_we;
  logic              r_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_sram_a;
  logic [DATA_W-1:0] r_sram_i;
  logic              r_sram_ce;
  logic              r_sram_csb;
  logic              r_sram_web;
  logic              r_sram_oeb;

  assign w_accept = bus.req_valid & r_ready;
  // On the accepting edge the latched direction is not yet valid, so take it from the bus.
  assign w_we_eff = w_accept ? bus.req_we : r_we;

  sram_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SETUP;
          w_cnt_load  = 1'b1;
          w_cnt_val   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = STROBE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = STROBE_LOAD;
        end
      end
      STROBE: begin
        if (w_cnt_zero) w_state_nxt = r_we ? RECOVER : OUTEN;
      end
      OUTEN:   w_state_nxt = SAMPLE;
      SAMPLE:  w_state_nxt = IDLE;
      RECOVER: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Every pin is a registered decode of the next state, so the macro sees glitch-free strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_sram_a    <= '0;
      r_sram_i    <= '0;
      r_sram_ce   <= 1'b0;
      r_sram_csb  <= 1'b1;
      r_sram_web  <= 1'b1;
      r_sram_oeb  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_sram_a <= bus.req_addr;
        if (bus.req_we) r_sram_i <= bus.req_wdata;
      end
      r_ready     <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == SAMPLE) || (w_state_nxt == RECOVER);
      if (w_state_nxt == SAMPLE) r_rsp_rdata <= sram_o;
      r_sram_ce   <= (w_state_nxt == STROBE);
      r_sram_csb  <= !(w_state_nxt inside {SETUP, STROBE, OUTEN, SAMPLE});
      r_sram_web  <= !(w_we_eff && (w_state_nxt inside {SETUP, STROBE}));
      r_sram_oeb  <= !(w_state_nxt inside {OUTEN, SAMPLE});
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign sram_a        = r_sram_a;
  assign sram_i        = r_sram_i;
  assign sram_ce       = r_sram_ce;
  assign sram_csb      = r_sram_csb;
  assign sram_web      = r_sram_web;
  assign sram_oeb      = r_sram_oeb;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed scoreboard bench for sram_ctrl driving SRAM256x16 models
module tb_sram_ctrl;
  import procik_mem_pkg::*;

  localparam int S0 = 1, T0 = 1, S1 = 3, T1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();

  logic [7:0]  a0, a1;
  logic [15:0] i0, i1;
  wire  [15:0] o0, o1;
  logic        ce0, csb0, web0, oeb0, ce1, csb1, web1, oeb1;

  sram_ctrl #(.SETUP_CYC(S0), .STROBE_CYC(T0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .sram_a(a0), .sram_i(i0), .sram_o(o0),
    .sram_ce(ce0), .sram_csb(csb0), .sram_web(web0), .sram_oeb(oeb0));
  SRAM256x16 u_sram0 (.CE1(ce0), .CSB1(csb0), .WEB1(web0), .OEB1(oeb0), .A1(a0), .I1(i0), .O1(o0));

  sram_ctrl #(.SETUP_CYC(S1), .STROBE_CYC(T1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .sram_a(a1), .sram_i(i1), .sram_o(o1),
    .sram_ce(ce1), .sram_csb(csb1), .sram_web(web1), .sram_oeb(oeb1));
  SRAM256x16 u_sram1 (.CE1(ce1), .CSB1(csb1), .WEB1(web1), .OEB1(oeb1), .A1(a1), .I1(i1), .O1(o1));

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl0 [256];
  logic [15:0] mdl1 [256];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          acc0, acc1;
  int          acc_cyc0 = -100;
  int          acc_cyc1 = -100;
  logic        h0_ce [16];
  logic        h0_rdy [16];
  logic        h0_oeb [16];
  logic        h1_ce [16];
  logic        h1_csb [16];
  logic [7:0]  h1_a [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Acceptance is decided from mid-cycle values; responses are scored at the following negedge.
  task automatic step();
    exp_t e;
    int   rel;
    if (bus0.req_valid && bus0.req_ready) begin
      e.we = bus0.req_we; e.addr = bus0.req_addr;
      e.data = bus0.req_we ? bus0.req_wdata : mdl0[bus0.req_addr];
      e.cyc = cyc + S0 + T0 + (bus0.req_we ? 1 : 2);
      q0.push_back(e); acc0 = 1'b1; acc_cyc0 = cyc;
    end
    if (bus1.req_valid && bus1.req_ready) begin
      e.we = bus1.req_we; e.addr = bus1.req_addr;
      e.data = bus1.req_we ? bus1.req_wdata : mdl1[bus1.req_addr];
      e.cyc = cyc + S1 + T1 + (bus1.req_we ? 1 : 2);
      q1.push_back(e); acc1 = 1'b1; acc_cyc1 = cyc;
    end
    @(negedge clk);
    cyc++;
    check("dut0 rsp_valid", bus0.rsp_valid, (q0.size() > 0 && q0[0].cyc == cyc));
    if (q0.size() > 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front();
      if (e.we) mdl0[e.addr] = e.data;
      else if (bus0.rsp_valid) check("dut0 rsp_rdata", bus0.rsp_rdata, e.data);
    end
    check("dut1 rsp_valid", bus1.rsp_valid, (q1.size() > 0 && q1[0].cyc == cyc));
    if (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      if (e.we) mdl1[e.addr] = e.data;
      else if (bus1.rsp_valid) check("dut1 rsp_rdata", bus1.rsp_rdata, e.data);
    end
    rel = cyc - acc_cyc0;
    if (rel >= 0 && rel < 16) begin
      h0_ce[rel] = ce0; h0_rdy[rel] = bus0.req_ready; h0_oeb[rel] = oeb0;
    end
    rel = cyc - acc_cyc1;
    if (rel >= 0 && rel < 16) begin
      h1_ce[rel] = ce1; h1_csb[rel] = csb1; h1_a[rel] = a1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_req0(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    bus0.req_we = we; bus0.req_addr = addr; bus0.req_wdata = wdata; bus0.req_valid = 1'b1;
    acc0 = 1'b0;
    for (int i = 0; i < 30 && !acc0; i++) step();
    check("dut0 accepted", acc0, 1);
    bus0.req_valid = 1'b0;
  endtask

  task automatic do_req1(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wdata; bus1.req_valid = 1'b1;
    acc1 = 1'b0;
    for (int i = 0; i < 30 && !acc1; i++) step();
    check("dut1 accepted", acc1, 1);
    bus1.req_valid = 1'b0;
  endtask

  initial begin
    int t1, t2, n_ce;
    rst_n = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", bus0.req_ready, 1);
    check("reset rsp_valid", bus0.rsp_valid, 0);
    check("reset rsp_rdata", bus0.rsp_rdata, 16'h0000);
    check("reset sram_csb", csb0, 1);
    check("reset sram_oeb", oeb0, 1);
    check("reset sram_ce", ce0, 0);
    check("reset sram_web", web0, 1);
    check("reset sram_a", a0, 8'h00);
    check("reset sram_i", i0, 16'h0000);
    rst_n = 1'b1;

    // Preload the macro contents through the controller.
    do_req0(1'b1, 8'h00, 16'h110B);
    do_req0(1'b1, 8'h0B, 16'h000F);
    do_req0(1'b1, 8'h0C, 16'h00F0);
    do_req0(1'b1, 8'h0D, 16'hFF00);
    idle(4);

    do_req0(1'b0, 8'h0B, 16'h0000);
    idle(5);
    check("read ce cycle1", h0_ce[1], 0);
    check("read ce cycle2", h0_ce[2], 1);
    check("read ce cycle3", h0_ce[3], 0);
    for (int r = 1; r <= 4; r++) check($sformatf("read ready cycle%0d", r), h0_rdy[r], 0);
    check("read ready cycle5", h0_rdy[5], 1);

    do_req0(1'b1, 8'h0E, 16'h1234);
    idle(4);
    for (int r = 1; r <= 4; r++) check($sformatf("write oeb cycle%0d", r), h0_oeb[r], 1);
    do_req0(1'b0, 8'h0E, 16'h0000);
    idle(5);

    bus0.req_we = 1'b0; bus0.req_addr = 8'h0C; bus0.req_valid = 1'b1;
    acc0 = 1'b0;
    for (int i = 0; i < 30 && !acc0; i++) step();
    t1 = acc_cyc0;
    bus0.req_addr = 8'h0D;
    acc0 = 1'b0;
    for (int i = 0; i < 30 && !acc0; i++) step();
    t2 = acc_cyc0;
    bus0.req_valid = 1'b0;
    check("held valid second accept", t2 - t1, 5);
    idle(6);

    do_req1(1'b1, 8'hFF, 16'hBEEF);
    idle(7);
    do_req1(1'b0, 8'hFF, 16'h0000);
    idle(9);
    n_ce = 0;
    for (int r = 1; r <= 9; r++) n_ce += int'(h1_ce[r]);
    check("slow ce high cycles", n_ce, 2);
    check("slow ce cycle4", h1_ce[4], 1);
    check("slow ce cycle5", h1_ce[5], 1);
    for (int r = 1; r <= 5; r++) begin
      check($sformatf("slow sram_a cycle%0d", r), h1_a[r], 8'hFF);
      check($sformatf("slow csb cycle%0d", r), h1_csb[r], 0);
    end

    do_req0(1'b1, 8'h00, 16'hAAAA);
    #1 rst_n = 1'b0;
    #1;
    check("abort req_ready", bus0.req_ready, 1);
    check("abort rsp_valid", bus0.rsp_valid, 0);
    check("abort rsp_rdata", bus0.rsp_rdata, 16'h0000);
    check("abort sram_csb", csb0, 1);
    check("abort sram_web", web0, 1);
    check("abort sram_ce", ce0, 0);
    check("abort sram_oeb", oeb0, 1);
    check("abort sram_a", a0, 8'h00);
    q0.delete();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    do_req0(1'b0, 8'h00, 16'h0000);
    idle(5);

    check("dut0 scoreboard drained", q0.size(), 0);
    check("dut1 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Initiator-side controller for the single-port SRAM256x16 macro. Accepts read/write requests from the core's fetch/load-store logic over a valid/ready handshake. Sequences the SRAM's chip-select, write-enable, output-enable and clock-enable strobe (CE1). Returns read data or a write acknowledge as a one-cycle response pulse. Sits between the procik-x1 core and the program/data SRAM.

## Interface
Parameters:
- SETUP_CYC, 1: cycles address/control are held stable before the CE rising edge (≥1).
- STROBE_CYC, 1: cycles CE is held high (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  8  word address.
- req_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle pulse: read data valid, or write complete.
- rsp_rdata  out  16  read data; holds last value until next read completes.
- sram_a  out  8  to SRAM A1.
- sram_i  out  16  to SRAM I1.
- sram_o  in  16  from SRAM O1; Z when sram_oeb=1.
- sram_ce  out  1  to SRAM CE1; rising edge performs the access.
- sram_csb  out  1  to SRAM CSB1, active-low.
- sram_web  out  1  to SRAM WEB1; 0 = write.
- sram_oeb  out  1  to SRAM OEB1, active-low.

## Operation
- All outputs are registered.
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - sram_a=0, sram_i=0.
  - sram_ce=0, sram_csb=1, sram_web=1, sram_oeb=1.
- Acceptance happens when req_valid && req_ready.
  - req_we, req_addr and req_wdata are latched at acceptance and ignored afterwards.
  - req_ready drops the next cycle.
- FSM states: IDLE, SETUP, STROBE, OUTEN, SAMPLE, RECOVER.
  - IDLE: sram_csb=1, sram_oeb=1, sram_ce=0. On acceptance go to SETUP.
  - SETUP: drive sram_a, sram_csb=0, and sram_web=~we. Drive sram_i only for writes. Hold sram_ce=0 for SETUP_CYC cycles, then go to STROBE.
  - STROBE: sram_ce=1 for STROBE_CYC cycles. Address, data and controls stay stable. Next state is OUTEN for a read, RECOVER for a write.
  - OUTEN (read only): sram_ce=0, sram_oeb=0, go to SAMPLE.
  - SAMPLE (read only): register sram_o into rsp_rdata, pulse rsp_valid, set sram_oeb=1 and sram_csb=1, go to IDLE.
  - RECOVER (write only): sram_ce=0, sram_csb=1, sram_web=1, pulse rsp_valid, go to IDLE.
- A wait-state down-counter reloads on entry to SETUP (SETUP_CYC-1) and to STROBE (STROBE_CYC-1). The state advances when the counter reaches 0.
- There is no response backpressure. The requester must accept rsp_valid when it pulses.
- sram_web and sram_a never change while sram_ce=1 (no spurious write or address glitch at the macro).
- sram_oeb=0 only in OUTEN and SAMPLE; it is never 0 during a write.

## Timing
- Acceptance is cycle 0.
- Read: rsp_valid is high in cycle SETUP_CYC+STROBE_CYC+2 (4 with defaults).
- Write: rsp_valid is high in cycle SETUP_CYC+STROBE_CYC+1 (3 with defaults).
- The write is committed at the sram_ce rising edge, cycle SETUP_CYC+1.
- Throughput: req_ready returns to 1 in the cycle after rsp_valid. With defaults, back-to-back reads are accepted every 5 cycles and writes every 4.
- The requester may hold req_valid across the busy period; the next request is accepted when req_ready is 1.
- Address 0xFF is a valid access with no wrap-around side effects. The controller never increments addresses.
- Reset mid-operation returns the controller asynchronously to IDLE with reset output values.
  - Reset before the STROBE state: no write occurs.
  - Reset in or after STROBE: the write has occurred; no rsp_valid is issued.
  - An aborted read produces no response, and rsp_rdata is cleared to 0.

## Structure
- Shared package procik_mem_pkg holds:
  - localparams ADDR_W=8, DATA_W=16, MEM_WORDS=256;
  - the sram_ctrl_state_t enum (IDLE, SETUP, STROBE, OUTEN, SAMPLE, RECOVER).
- One sub-module: sram_phase_cnt, a loadable down-counter with a zero flag sized for max(SETUP_CYC, STROBE_CYC).
- The bench instantiates SRAM256x16 as the responder, with preloaded contents: word 0x0B=0x000F, word 0x0C=0x00F0, word 0x0D=0xFF00.

## Test plan
- Reset, then check outputs: req_ready=1, sram_csb=1, sram_oeb=1, sram_ce=0, rsp_rdata=0.
- Read addr 0x0B at cycle 0:
  - sram_ce rises in cycle 2;
  - rsp_valid=1 with rsp_rdata=0x000F in cycle 4;
  - req_ready=0 during cycles 1–4.
- Write 0x1234 to 0x0E, then read 0x0E:
  - write rsp_valid in cycle 3;
  - read returns 0x1234;
  - sram_oeb stays 1 throughout the write.
- req_valid held with two reads (0x0C, then 0x0D):
  - second read accepted in cycle 5;
  - responses 0x00F0 in cycle 4 and 0xFF00 in cycle 9.
- SETUP_CYC=3, STROBE_CYC=2:
  - read 0xFF after a write of 0xBEEF returns 0xBEEF at latency 7;
  - sram_ce is high for exactly 2 cycles;
  - sram_a is stable for all 5 SETUP+STROBE cycles.
- rst_n pulsed low during SETUP of a write 0xAAAA to 0x00:
  - outputs return to reset values immediately;
  - no rsp_valid;
  - a later read of 0x00 returns the original 0x110B.
